// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, stall hold vectors,
// stall bit positions and the core-wide address bus constants.
package pipe_ctrl_pkg;

    // Instruction address bus width and its zero value, as used across the core.
    localparam int unsigned INST_ADDR_W = 32;
    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

    // Bit positions inside the stall hold vector.
    localparam int unsigned STALL_BIT_PC  = 0;
    localparam int unsigned STALL_BIT_IF  = 1;
    localparam int unsigned STALL_BIT_ID  = 2;
    localparam int unsigned STALL_BIT_EX  = 3;
    localparam int unsigned STALL_BIT_MEM = 4;
    localparam int unsigned STALL_BIT_WB  = 5;
    localparam int unsigned STALL_W       = STALL_BIT_WB + 1;

    // A stalling stage holds itself and every stage upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE   = '0;
    localparam logic [STALL_W-1:0] STALL_ID     = STALL_W'((1 << (STALL_BIT_ID + 1)) - 1);
    localparam logic [STALL_W-1:0] STALL_EX     = STALL_W'((1 << (STALL_BIT_EX + 1)) - 1);
    localparam logic [STALL_W-1:0] STALL_MEM    = STALL_W'((1 << (STALL_BIT_MEM + 1)) - 1);
    // Freeze pc..mem while the exception is accepted; wb still retires.
    localparam logic [STALL_W-1:0] STALL_FREEZE = STALL_MEM;

    typedef enum logic [1:0] {
        STATE_RUN,
        STATE_STALL,
        STATE_FLUSH
    } state_e;

    // Highest requesting stage wins.
    function automatic logic [STALL_W-1:0] stall_encode(input logic req_id,
                                                        input logic req_ex,
                                                        input logic req_mem);
        if (req_mem) begin
            return STALL_MEM;
        end else if (req_ex) begin
            return STALL_EX;
        end else if (req_id) begin
            return STALL_ID;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: consecutive-stall counter with a sticky timeout flag, plus a
// saturating count of all stalled cycles for performance monitoring.
module pipe_ctrl_stall_watchdog #(
    parameter int unsigned MAX_STALL = 255,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_active,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    // Next-state: run length parks at MAX_STALL, total count saturates at all-ones.
    always_comb begin
        run_d     = run_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        if (stall_active) begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
            if (cycles_q != '1) begin
                cycles_d = cycles_q + CNT_W'(1);
            end
        end else begin
            run_d = '0;
        end
        if (stall_active && (run_d == RUN_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

    assign stall_timeout = timeout_q;
    assign stall_cycles  = cycles_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: arbitrates stage stall requests against exception
// flushes, drives the hold vector and flush to the pipeline registers, and
// redirects fetch to the handler address.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = INST_ADDR_W,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               flush_req,
    input  logic [ADDR_W-1:0]  flush_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [ADDR_W-1:0]  new_pc,
    output logic               pc_redirect,
    output logic               stall_timeout,
    output logic [CNT_W-1:0]   stall_cycles
);

    // Flush length counter counts down to zero in the last FLUSH cycle.
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         fcnt_q, fcnt_d;
    logic               flush_q, flush_d;
    logic               redirect_q, redirect_d;
    logic [ADDR_W-1:0]  new_pc_q, new_pc_d;
    logic [STALL_W-1:0] stall_vec;
    logic               any_req;

    assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

    // Next-state, registered-output next values and the combinational hold vector.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        flush_d    = flush_q;
        redirect_d = 1'b0;
        new_pc_d   = new_pc_q;
        stall_vec  = STALL_NONE;
        unique case (state_q)
            STATE_RUN, STATE_STALL: begin
                if (flush_req) begin
                    // Exception wins over any stall request this cycle.
                    stall_vec  = STALL_FREEZE;
                    state_d    = STATE_FLUSH;
                    fcnt_d     = FLUSH_LAST;
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                    new_pc_d   = flush_pc;
                end else begin
                    stall_vec = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
                    state_d   = any_req ? STATE_STALL : STATE_RUN;
                end
            end
            STATE_FLUSH: begin
                // Later flush requests are dropped: the older exception owns new_pc.
                if (fcnt_q == '0) begin
                    state_d = STATE_RUN;
                    flush_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = STATE_RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= STATE_RUN;
            fcnt_q     <= '0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            new_pc_q   <= ADDR_W'(ZERO_WORD);
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            new_pc_q   <= new_pc_d;
        end
    end

    // Hold vector is zero-latency; forced idle while reset is asserted.
    assign stall       = rst ? stall_vec : STALL_NONE;
    assign flush       = flush_q;
    assign pc_redirect = redirect_q;
    assign new_pc      = new_pc_q;

    pipe_ctrl_stall_watchdog #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) u_stall_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall_active  (|stall),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver applies stimulus and pushes the
// reference model's expected outputs; a monitor pops and compares each cycle.
module tb_pipe_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned FC = 3;
    localparam int unsigned MS = 8;
    localparam int unsigned CW = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sid = 1'b0, sex = 1'b0, smem = 1'b0, freq = 1'b0;
    logic [AW-1:0] fpc = '0;
    logic [5:0]    stall;
    logic          flush, pc_redirect, stall_timeout;
    logic [AW-1:0] new_pc;
    logic [CW-1:0] stall_cycles;

    pipe_ctrl #(
        .ADDR_W       (AW),
        .FLUSH_CYCLES (FC),
        .MAX_STALL    (MS),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id   (sid),
        .stallreq_ex   (sex),
        .stallreq_mem  (smem),
        .flush_req     (freq),
        .flush_pc      (fpc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .pc_redirect   (pc_redirect),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    stall;
        logic          flush;
        logic [AW-1:0] new_pc;
        logic          redir;
        logic          tmo;
        logic [CW-1:0] cyc;
        int            cycle;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc_no = 0;

    // Reference model state (values as seen after the most recent clock edge).
    int            m_flush_left;
    int            m_consec;
    int            m_total;
    bit            m_tmo;
    logic [AW-1:0] m_pc;

    // Inputs held during the previous cycle.
    bit            p_valid = 0;
    bit            p_rst, p_id, p_ex, p_mem, p_fr;
    logic [AW-1:0] p_pc;

    function automatic logic [5:0] model_stall(bit fr, bit id, bit ex, bit mem);
        if (m_flush_left > 0) return 6'b000000;
        if (fr)  return 6'b011111;
        if (mem) return 6'b011111;
        if (ex)  return 6'b001111;
        if (id)  return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_consec     = 0;
        m_total      = 0;
        m_tmo        = 0;
        m_pc         = '0;
    endtask

    task automatic model_step();
        logic [5:0] s;
        s = model_stall(p_fr, p_id, p_ex, p_mem);
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (p_fr) begin
            m_flush_left = FC;
            m_pc         = p_pc;
        end
        if (s != 0) begin
            m_consec++;
            if (m_consec >= MS) m_tmo = 1;
            if (m_total < CNT_MAX) m_total++;
        end else begin
            m_consec = 0;
        end
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic drive(input bit r, input bit id, input bit ex, input bit mem,
                         input bit fr, input logic [AW-1:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        cyc_no++;
        if (p_valid && p_rst) model_step();
        rst  = r;
        sid  = id;
        sex  = ex;
        smem = mem;
        freq = fr;
        fpc  = pc;
        if (!r) model_reset();
        p_valid = 1; p_rst = r; p_id = id; p_ex = ex; p_mem = mem; p_fr = fr; p_pc = pc;
        e.stall  = r ? model_stall(fr, id, ex, mem) : 6'b000000;
        e.flush  = r && (m_flush_left > 0);
        e.redir  = r && (m_flush_left == FC);
        e.new_pc = m_pc;
        e.tmo    = m_tmo;
        e.cyc    = CW'(m_total);
        e.cycle  = cyc_no;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, '0);
    endtask

    task automatic chk(input string name, input int cycle, input logic [AW-1:0] act,
                       input logic [AW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall",         e.cycle, AW'(stall),        AW'(e.stall));
            chk("flush",         e.cycle, AW'(flush),        AW'(e.flush));
            chk("pc_redirect",   e.cycle, AW'(pc_redirect),  AW'(e.redir));
            chk("new_pc",        e.cycle, new_pc,            e.new_pc);
            chk("stall_timeout", e.cycle, AW'(stall_timeout), AW'(e.tmo));
            chk("stall_cycles",  e.cycle, AW'(stall_cycles), AW'(e.cyc));
        end
    end

    initial begin
        model_reset();
        // Reset held with random inputs.
        for (int i = 0; i < 3; i++)
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        idle(10);

        // Priority: ex beats id, three stalled cycles counted.
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, '0);
        idle(2);

        // Flush during a mem stall.
        drive(1, 0, 0, 1, 0, '0);
        drive(1, 0, 0, 1, 1, 32'h0000_0040);
        idle(5);

        // Nested flush: second request inside FLUSH is ignored.
        drive(1, 0, 0, 0, 1, 32'h0000_0100);
        idle(1);
        drive(1, 0, 0, 0, 1, 32'h0000_0200);
        idle(5);

        // Watchdog trips at exactly MS consecutive stalled cycles and sticks.
        drive(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) drive(1, 0, 1, 0, 0, '0);
        idle(4);

        // Two 7-cycle stalls separated by an idle cycle never trip it.
        drive(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 7; i++) drive(1, 0, 1, 0, 0, '0);
        idle(1);
        for (int i = 0; i < 7; i++) drive(1, 0, 1, 0, 0, '0);
        idle(3);

        // Asynchronous reset in the second FLUSH cycle, then no redirect.
        drive(1, 0, 0, 0, 1, 32'h0000_0080);
        idle(1);
        drive(0, 0, 0, 0, 0, '0);
        idle(6);

        // stall_cycles saturation.
        drive(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < CNT_MAX + 6; i++) drive(1, 0, 0, 1, 0, '0);
        idle(3);

        // Randomized traffic with occasional resets.
        drive(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 14) == 0),
                  $urandom);
        end
        idle(3);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. Drives hold (stall) enables and clear (flush) to the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Arbitrates stall requests from the id/ex/mem stages against exception flush requests, and redirects fetch to the handler PC.
- Tracks stall duration with a watchdog and a saturating performance counter.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrBus)
- FLUSH_CYCLES, 1, cycles flush stays asserted (1..15)
- MAX_STALL, 255, consecutive stalled cycles before stall_timeout sets
- CNT_W, 16, width of stall_cycles performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- stallreq_id  in  1  id stage hazard (load-use)
- stallreq_ex  in  1  ex stage multi-cycle op (mul/div)
- stallreq_mem  in  1  data bus wait
- flush_req  in  1  exception/redirect request from mem stage, single-cycle pulse
- flush_pc  in  ADDR_W  handler address, valid with flush_req
- stall  out  6  hold vector: [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb
- flush  out  1  synchronous clear to all pipeline registers
- new_pc  out  ADDR_W  redirect target
- pc_redirect  out  1  one-cycle pulse: pc loads new_pc
- stall_timeout  out  1  sticky watchdog flag
- stall_cycles  out  CNT_W  saturating count of cycles with stall != 0

Behaviour:
- Reset (rst=0, async):
  - state=RUN
  - stall=6'b000000, flush=0, pc_redirect=0
  - new_pc=0, stall_timeout=0, stall_cycles=0
  - all internal counters cleared
- FSM states RUN, STALL, FLUSH. Registered state; stall is combinational from state + inputs.
- Stall encoding (highest requesting stage wins):
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else 6'b000000
- RUN:
  - flush_req → capture flush_pc into new_pc; go to FLUSH.
  - Else any stallreq → STALL.
  - Else stay.
- STALL:
  - flush_req → FLUSH (flush beats stall).
  - No stallreq → RUN.
  - Else stay.
- Cycle with flush_req=1 in RUN/STALL:
  - stall forced to 6'b011111 (freeze pc..mem; wb retires). Stall requests are ignored this cycle.
- FLUSH:
  - flush=1, stall=6'b000000 for exactly FLUSH_CYCLES cycles, beginning the cycle after flush_req.
  - pc_redirect=1 in the first FLUSH cycle only; new_pc is stable throughout FLUSH.
  - Exit to RUN after the last FLUSH cycle. The first RUN cycle evaluates stallreq normally.
- flush_req during FLUSH: ignored (new_pc not updated). The older exception owns the redirect.
- Watchdog:
  - stall_run counter increments each cycle stall != 0; clears on any cycle with stall == 0.
  - On reaching MAX_STALL, stall_timeout sets and holds until reset. The counter stops at MAX_STALL.
  - The stall itself is not broken.
- stall_cycles: +1 each cycle stall != 0 (including the flush_req freeze cycle); saturates at 2^CNT_W-1.
- All outputs registered except stall (combinational, zero latency, required for the hazard to hold in the same cycle).
- Reset asserted mid-FLUSH or mid-STALL: immediate return to reset values. No redirect pulse after release.

Decomposition:
- Shared package/include (precompiled defines):
  - state encodings: STATE_RUN, STATE_STALL, STATE_FLUSH
  - stall vector constants: STALL_NONE, STALL_ID, STALL_EX, STALL_MEM, STALL_FREEZE
  - stall bit indices
  - reuse of InstAddrBus / ZeroWord
- One natural sub-module: stall_watchdog, holding stall_run, stall_timeout and the saturating stall_cycles counter. Input is (stall != 0).

Test Plan:
- Reset: rst=0 with random inputs → all outputs 0, state RUN; release rst with no requests → stall=000000 for 10 cycles.
- Priority: stallreq_id=1 and stallreq_ex=1 for 3 cycles → stall=001111 those 3 cycles; drop both → stall=000000 next cycle; stall_cycles=3.
- Flush during stall: stallreq_mem=1, then flush_req=1 with flush_pc=0x00000040 → that cycle stall=011111; next cycle flush=1, pc_redirect=1, new_pc=0x40, stall=000000; following cycle flush=0 (FLUSH_CYCLES=1), state RUN.
- Flush length and nested flush: FLUSH_CYCLES=3, flush_req at t, second flush_req at t+2 with different pc → flush=1 for t+1..t+3; pc_redirect only at t+1; new_pc keeps the first address.
- Watchdog: MAX_STALL=8, stallreq_ex held 8 cycles → stall_timeout rises on the 8th cycle and stays 1 after the request drops; 7-cycle stall, 1 idle, 7-cycle stall → stall_timeout stays 0.
- Async reset mid-FLUSH: FLUSH_CYCLES=3, rst low between clock edges in the 2nd FLUSH cycle → flush and pc_redirect drop immediately; after release, no pc_redirect occurs.
